// File: rtl/fxp_matmul_pipe_if.sv
// Handshake/bus bundle for fxp_matmul_pipe: operand/tag input channel and result output channel.
interface fxp_matmul_pipe_if #(
  parameter int N     = 4,
  parameter int NCH   = 4,
  parameter int W     = 26,
  parameter int TAG_W = 104
);
  // Both channels are valid/ready: a transfer happens on a rising edge where valid && ready;
  // the producer holds its payload stable while valid is high and ready is low.
  logic                 in_valid;
  logic                 in_ready;
  logic [NCH*N*N*W-1:0] a_flat;
  logic [NCH*N*N*W-1:0] b_flat;
  logic [TAG_W-1:0]     in_tag;
  logic                 round_en;
  logic                 out_valid;
  logic                 out_ready;
  logic [NCH*N*N*W-1:0] c_flat;
  logic [TAG_W-1:0]     out_tag;
  logic [NCH-1:0]       sat_flag;

  modport master (
    output in_valid, a_flat, b_flat, in_tag, round_en, out_ready,
    input  in_ready, out_valid, c_flat, out_tag, sat_flag
  );

  modport slave (
    input  in_valid, a_flat, b_flat, in_tag, round_en, out_ready,
    output in_ready, out_valid, c_flat, out_tag, sat_flag
  );
endinterface

// File: rtl/fxp_matmul_pipe.sv
// Multi-channel NxN signed fixed-point matrix multiply, one k-term per cycle, with
// selectable rounding, saturating normalisation and a tag carried alongside the job.
module fxp_matmul_pipe #(
  parameter int N     = 4,
  parameter int NCH   = 4,
  parameter int W     = 26,
  parameter int FRAC  = 13,
  parameter int TAG_W = 104
) (
  input  logic             clk_mul,
  input  logic             rst_n,
  fxp_matmul_pipe_if.slave bus,
  output logic [1:0]       dbg_state
);

  localparam int KW = $clog2(N);
  localparam int AW = 2*W + $clog2(N);
  localparam int MW = NCH*N*N*W;
  localparam logic [KW-1:0] K_LAST = KW'(N-1);
  localparam logic signed [AW-1:0] SAT_MAX  = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN  = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [AW-1:0] RND_HALF = AW'(1) << (FRAC-1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_NORM = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [MW-1:0]      a_q, a_d;
  logic [MW-1:0]      b_q, b_d;
  logic               rnd_q, rnd_d;
  logic [MW-1:0]      c_q, c_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [NCH-1:0]     sat_q, sat_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic signed [AW-1:0] acc_q [NCH][N][N];
  logic signed [AW-1:0] acc_d [NCH][N][N];

  logic signed [W-1:0]   ea, eb;
  logic signed [2*W-1:0] prod;
  logic signed [AW-1:0]  rnd_add, s, sh;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    a_d         = a_q;
    b_d         = b_q;
    rnd_d       = rnd_q;
    c_d         = c_q;
    tag_d       = tag_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    acc_d       = acc_q;
    ea          = '0;
    eb          = '0;
    prod        = '0;
    rnd_add     = rnd_q ? RND_HALF : '0;
    s           = '0;
    sh          = '0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d        = bus.a_flat;
          b_d        = bus.b_flat;
          tag_d      = bus.in_tag;
          rnd_d      = bus.round_en;
          sat_d      = '0;
          k_d        = '0;
          in_ready_d = 1'b0;
          state_d    = S_ACC;
          for (int c = 0; c < NCH; c++)
            for (int i = 0; i < N; i++)
              for (int j = 0; j < N; j++)
                acc_d[c][i][j] = '0;
        end
      end

      S_ACC: begin
        // Term k of every dot product: A column k times B row k, across all channels.
        for (int c = 0; c < NCH; c++)
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
              ea   = a_q[((c*N+i)*N+int'(k_q))*W +: W];
              eb   = b_q[((c*N+int'(k_q))*N+j)*W +: W];
              prod = ea * eb;
              acc_d[c][i][j] = acc_q[c][i][j] + AW'(prod);
            end
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = S_NORM;
        end else begin
          k_d = k_q + KW'(1);
        end
      end

      S_NORM: begin
        // The accumulator is wide enough that the half-LSB add cannot wrap.
        for (int c = 0; c < NCH; c++)
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
              s  = acc_q[c][i][j] + rnd_add;
              sh = s >>> FRAC;
              if (sh > SAT_MAX) begin
                c_d[((c*N+i)*N+j)*W +: W] = SAT_MAX[W-1:0];
                sat_d[c] = 1'b1;
              end else if (sh < SAT_MIN) begin
                c_d[((c*N+i)*N+j)*W +: W] = SAT_MIN[W-1:0];
                sat_d[c] = 1'b1;
              end else begin
                c_d[((c*N+i)*N+j)*W +: W] = sh[W-1:0];
              end
            end
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end

      S_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_mul or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rnd_q       <= 1'b0;
      c_q         <= '0;
      tag_q       <= '0;
      sat_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      for (int c = 0; c < NCH; c++)
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            acc_q[c][i][j] <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rnd_q       <= rnd_d;
      c_q         <= c_d;
      tag_q       <= tag_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      acc_q       <= acc_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.c_flat    = c_q;
  assign bus.out_tag   = tag_q;
  assign bus.sat_flag  = sat_q;
  assign dbg_state     = state_q;

endmodule

// File: doc/fxp_matmul_pipe.md
Name: fxp_matmul_pipe

Overview:
- Parametrised successor of the fixed 4x4, 4-channel single-cycle matrix multiplier used in the FastICA (zTw)^3 datapath.
- Computes C = A*B for NCH independent NxN signed fixed-point matrix pairs, one k-term per cycle.
- Adds a valid/ready handshake, a selectable rounding mode, saturating normalisation and a sideband tag pass-through that replaces the z-vector delay.
- Sits between the (zTw)^2 stage and the weight-update stage.

Parameters:
- N, 4: matrix dimension (N>=2).
- NCH, 4: number of independent channels.
- W, 26: element width, signed two's complement.
- FRAC, 13: fractional bits (Q(W-FRAC).FRAC); 1.0 = 2^FRAC.
- TAG_W, 104: sideband width (default carries 4 x 26-bit z).

Ports:
- clk_mul  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  A/B/tag valid.
- in_ready  out  1  block can accept.
- a_flat  in  NCH*N*N*W  A matrices. Element (ch,i,j) is at bit offset ((ch*N+i)*N+j)*W.
- b_flat  in  NCH*N*N*W  B matrices, same packing as a_flat.
- in_tag  in  TAG_W  sideband, captured with A/B.
- round_en  in  1  1 = round half-up, 0 = truncate (floor). Sampled at accept.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- c_flat  out  NCH*N*N*W  results, same packing as a_flat.
- out_tag  out  TAG_W  captured in_tag.
- sat_flag  out  NCH  per channel: any element of that channel saturated.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; in_ready=1; out_valid=0.
  - c_flat, out_tag, sat_flag, accumulators and counter all cleared to 0.
  - Reset mid-operation discards the in-flight job; no partial output ever appears.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture A, B, tag and round_en; clear accumulators; k=0; go to ACC.
  - ACC: in_ready=0. Each cycle, for all ch,i,j: acc[ch][i][j] += A[ch][i][k]*B[ch][k][j]; then k++. When k==N-1 is processed, go to NORM.
  - NORM: one cycle. Register the normalised results into c_flat, set sat_flag, set out_valid=1, go to OUT.
  - OUT: c_flat, out_tag and sat_flag held stable. When out_valid&&out_ready: out_valid=0, go to IDLE. in_ready=0 throughout OUT; no bypass to a new accept in the same cycle.
- Latency:
  - Accept edge = e0. ACC runs on edges e1..eN. NORM occurs at e(N+1), and out_valid is high after edge e(N+1).
  - Minimum initiation interval is N+3 cycles (with out_ready held high).
- Arithmetic:
  - Product width 2W. Accumulator width 2W+clog2(N); no wrap is possible.
  - round_en=1: s = acc + 2^(FRAC-1), then arithmetic shift right by FRAC.
  - round_en=0: arithmetic shift right by FRAC (floor).
  - Saturation: if the shifted value is > 2^(W-1)-1, output 2^(W-1)-1; if < -2^(W-1), output -2^(W-1). Either case sets sat_flag[ch].
  - This replaces the legacy unsaturated bit-slice [W+FRAC-1:FRAC].
- Boundary conditions:
  - in_valid while busy is ignored; the upstream must hold its data until in_ready.
  - A/B/round_en changes after accept have no effect.
  - out_ready may be held low indefinitely; outputs stay stable.
  - out_ready high before out_valid has no effect.
  - sat_flag is cleared at each accept.

Test Plan:
- Identity: ch0 A = 8192*I, B = {1..16}*8192. With round_en=0, C equals B exactly; sat_flag=0; out_valid high after 5 edges from accept (N=4); out_tag equals in_tag.
- Rounding: A[0][0]=1, B[0][0]=4096, all other elements 0.
  - B[0][0]=4096: C[0][0]=0 with truncate, 1 with round.
  - B[0][0]=-4096: C[0][0]=-1 with truncate, 0 with round.
- Saturation: ch2 A and B all 33554431. Every ch2 element is 33554431, sat_flag=4'b0100. Repeat with A all -33554432 and B all 33554431: every ch2 element is -33554432.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Outputs stay stable, in_ready=0, and a new in_valid is ignored. Releasing out_ready returns the block to IDLE and the next job is accepted on the following edge.
- Reset: assert rst_n=0 during ACC (k=2). All outputs become 0 immediately; after release the next job produces the correct result with no residue from the aborted job.
- Parametrisation: N=2, NCH=1, W=16, FRAC=8. A=[[256,512],[0,256]], B=[[256,0],[256,256]] gives C=[[768,512],[256,256]], with out_valid high 3 edges after accept.
